// File: rtl/program_memory_loader_pkg.sv
// Shared definitions for the loadable MIPS program memory.
package program_memory_loader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOADING,
    ST_RUN
  } state_t;

  localparam logic [31:0] NOP                  = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_BASE_ADDRESS = 32'h0040_0000;

  // Word-address width for a memory of the given depth (at least one bit).
  function automatic int unsigned addr_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/program_memory_loader_if.sv
// Boot-load and fetch bus between the loader source / fetch stage and the program memory.
interface program_memory_loader_if #(
  parameter int unsigned MEMORY_DEPTH = 64,
  parameter int unsigned DATA_WIDTH   = 32
);
  localparam int unsigned CNT_W = $clog2(MEMORY_DEPTH + 1);

  logic                  LoadStart;
  logic [DATA_WIDTH-1:0] LoadData;
  logic                  LoadValid;
  logic                  LoadLast;
  logic                  LoadReady;
  logic                  LoadDone;
  logic [CNT_W-1:0]      LoadCount;
  logic                  FetchEnable;
  logic [DATA_WIDTH-1:0] Address;
  logic [DATA_WIDTH-1:0] Instruction;
  logic                  InstructionValid;
  logic                  Fault;

  modport master (
    output LoadStart, LoadData, LoadValid, LoadLast, FetchEnable, Address,
    input  LoadReady, LoadDone, LoadCount, Instruction, InstructionValid, Fault
  );

  modport slave (
    input  LoadStart, LoadData, LoadValid, LoadLast, FetchEnable, Address,
    output LoadReady, LoadDone, LoadCount, Instruction, InstructionValid, Fault
  );

endinterface

// File: rtl/program_memory_loader_ram_dp.sv
// Simple dual-port RAM: one synchronous write port, one synchronous read port, no reset.
module program_ram_dp #(
  parameter int unsigned DEPTH  = 64,
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned ADDR_W = 6
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WIDTH-1:0]  rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Write port: store the accepted load word.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Read port: registered read, holds its value when not enabled.
  always_ff @(posedge clk) begin
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/program_memory_loader.sv
// Loadable program memory: valid/ready boot-load port, registered checked fetch port.
module program_memory_loader
  import program_memory_loader_pkg::*;
#(
  parameter int unsigned           MEMORY_DEPTH = 64,
  parameter int unsigned           DATA_WIDTH   = 32,
  parameter logic [DATA_WIDTH-1:0] BASE_ADDRESS = DATA_WIDTH'(DEFAULT_BASE_ADDRESS)
) (
  input logic                    clk,
  input logic                    reset,
  program_memory_loader_if.slave bus
);

  localparam int unsigned ADDR_W = addr_width(MEMORY_DEPTH);
  localparam int unsigned CNT_W  = $clog2(MEMORY_DEPTH + 1);

  state_t                state;
  logic [CNT_W-1:0]      load_count;
  logic                  load_done;
  logic                  fetch_valid;
  logic                  fetch_fault;
  logic                  fetch_hit;
  logic                  accept;
  logic                  last_word;
  logic                  fetch_req;
  logic                  fetch_bad;
  logic [DATA_WIDTH-1:0] index;
  logic [DATA_WIDTH-1:0] ram_q;

  // Load handshake and fetch range/alignment check, evaluated in the request cycle.
  always_comb begin
    accept    = (state == ST_LOADING) && bus.LoadValid && !bus.LoadStart;
    last_word = (load_count == CNT_W'(MEMORY_DEPTH - 1));
    fetch_req = (state == ST_RUN) && bus.FetchEnable;
    // BASE_ADDRESS is word aligned, so subtracting word addresses equals (Address-BASE)>>2.
    index     = (bus.Address >> 2) - (BASE_ADDRESS >> 2);
    fetch_bad = (bus.Address[1:0] != 2'b00) ||
                (bus.Address < BASE_ADDRESS) ||
                (index >= DATA_WIDTH'(load_count));
  end

  // Control FSM, load counter and fetch status registers; a restart overrides everything else.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= ST_IDLE;
      load_count  <= '0;
      load_done   <= 1'b0;
      fetch_valid <= 1'b0;
      fetch_fault <= 1'b0;
      fetch_hit   <= 1'b0;
    end else begin
      fetch_valid <= 1'b0;
      unique case (state)
        ST_LOADING: begin
          if (accept) begin
            load_count <= load_count + CNT_W'(1);
            if (bus.LoadLast || last_word) begin
              state     <= ST_RUN;
              load_done <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          if (bus.FetchEnable) begin
            fetch_valid <= 1'b1;
            fetch_fault <= fetch_bad;
            fetch_hit   <= !fetch_bad;
          end
        end
        default: ;
      endcase
      if (bus.LoadStart) begin
        state      <= ST_LOADING;
        load_count <= '0;
        load_done  <= 1'b0;
      end
    end
  end

  // RAM is read only for in-range fetches; the registered hit flag masks stale or
  // unloaded data so Instruction reads as NOP after reset and after a fault.
  program_ram_dp #(
    .DEPTH (MEMORY_DEPTH),
    .WIDTH (DATA_WIDTH),
    .ADDR_W(ADDR_W)
  ) u_ram (
    .clk    (clk),
    .wr_en  (accept),
    .wr_addr(load_count[ADDR_W-1:0]),
    .wr_data(bus.LoadData),
    .rd_en  (fetch_req && !fetch_bad),
    .rd_addr(index[ADDR_W-1:0]),
    .rd_data(ram_q)
  );

  assign bus.LoadReady        = (state == ST_LOADING) && !bus.LoadStart;
  assign bus.LoadDone         = load_done;
  assign bus.LoadCount        = load_count;
  assign bus.Instruction      = fetch_hit ? ram_q : DATA_WIDTH'(NOP);
  assign bus.InstructionValid = fetch_valid;
  assign bus.Fault            = fetch_fault;

endmodule

// File: tb/tb_program_memory_loader.sv
// Self-checking bench for program_memory_loader: behavioural model plus directed and random stimulus.
module tb_program_memory_loader;

  localparam int unsigned DEPTH = 20;
  localparam logic [31:0] BASE  = 32'h0040_0000;
  localparam int M_IDLE = 0;
  localparam int M_LOAD = 1;
  localparam int M_RUN  = 2;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  program_memory_loader_if #(.MEMORY_DEPTH(DEPTH), .DATA_WIDTH(32)) bus ();

  program_memory_loader #(
    .MEMORY_DEPTH(DEPTH),
    .DATA_WIDTH  (32),
    .BASE_ADDRESS(BASE)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  bit cmp_on   = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: mode, image contents, word count and last fetch result.
  int          m_mode   = M_IDLE;
  int          m_cnt    = 0;
  bit          m_done   = 1'b0;
  bit          m_ivalid = 1'b0;
  bit          m_fault  = 1'b0;
  logic [31:0] m_instr  = 32'h0;
  logic [31:0] m_img [DEPTH];

  always @(posedge clk or negedge reset) begin
    int      old_mode;
    longint  a;
    longint  idx;
    if (!reset) begin
      m_mode = M_IDLE; m_cnt = 0; m_done = 1'b0;
      m_ivalid = 1'b0; m_fault = 1'b0; m_instr = 32'h0;
    end else begin
      old_mode = m_mode;
      m_ivalid = 1'b0;
      if (old_mode == M_LOAD && bus.LoadValid && !bus.LoadStart) begin
        m_img[m_cnt] = bus.LoadData;
        m_cnt++;
        if (bus.LoadLast || m_cnt == DEPTH) begin
          m_mode = M_RUN;
          m_done = 1'b1;
        end
      end
      if (old_mode == M_RUN && bus.FetchEnable) begin
        a   = longint'(bus.Address);
        idx = (a - longint'(BASE)) / 4;
        m_ivalid = 1'b1;
        if ((a % 4) != 0 || a < longint'(BASE) || idx >= m_cnt) begin
          m_fault = 1'b1;
          m_instr = 32'h0;
        end else begin
          m_fault = 1'b0;
          m_instr = m_img[idx];
        end
      end
      if (bus.LoadStart) begin
        m_mode = M_LOAD;
        m_cnt  = 0;
        m_done = 1'b0;
      end
    end
  end

  // Compare every output against the model away from the active edge.
  always @(negedge clk) begin
    if (cmp_on) begin
      chk("LoadReady", 32'(bus.LoadReady), 32'(m_mode == M_LOAD && !bus.LoadStart));
      chk("LoadDone", 32'(bus.LoadDone), 32'(m_done));
      chk("LoadCount", 32'(bus.LoadCount), m_cnt);
      chk("InstructionValid", 32'(bus.InstructionValid), 32'(m_ivalid));
      chk("Fault", 32'(bus.Fault), 32'(m_fault));
      chk("Instruction", bus.Instruction, m_instr);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic load_word(input logic [31:0] data, input logic last);
    bus.LoadValid = 1'b1;
    bus.LoadData  = data;
    bus.LoadLast  = last;
    cyc();
  endtask

  task automatic start_load();
    bus.LoadStart = 1'b1;
    cyc();
    bus.LoadStart = 1'b0;
  endtask

  task automatic fetch(input logic [31:0] addr);
    bus.FetchEnable = 1'b1;
    bus.Address     = addr;
    cyc();
  endtask

  initial begin
    bus.LoadStart   = 1'b0;
    bus.LoadData    = 32'h0;
    bus.LoadValid   = 1'b0;
    bus.LoadLast    = 1'b0;
    bus.FetchEnable = 1'b0;
    bus.Address     = 32'h0;
    cmp_on          = 1'b1;

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    chk("rst_LoadDone", 32'(bus.LoadDone), 32'h0);
    chk("rst_LoadCount", 32'(bus.LoadCount), 32'h0);
    chk("rst_LoadReady", 32'(bus.LoadReady), 32'h0);
    chk("rst_Instruction", bus.Instruction, 32'h0);
    chk("rst_InstructionValid", 32'(bus.InstructionValid), 32'h0);
    chk("rst_Fault", 32'(bus.Fault), 32'h0);
    #2 reset = 1'b1;

    // Fetch before any load is ignored.
    cyc();
    fetch(BASE);
    bus.FetchEnable = 1'b0;
    chk("idle_fetch_valid", 32'(bus.InstructionValid), 32'h0);
    chk("idle_fetch_instr", bus.Instruction, 32'h0);
    chk("idle_LoadDone", 32'(bus.LoadDone), 32'h0);

    // Three-word program with LoadLast on the third word.
    start_load();
    load_word(32'h2008_0005, 1'b0);
    load_word(32'h2009_0003, 1'b0);
    load_word(32'h0109_5020, 1'b1);
    bus.LoadValid = 1'b0;
    bus.LoadLast  = 1'b0;
    chk("prog_LoadDone", 32'(bus.LoadDone), 32'h1);
    chk("prog_LoadCount", 32'(bus.LoadCount), 32'd3);

    fetch(BASE);
    chk("fetch0_instr", bus.Instruction, 32'h2008_0005);
    chk("fetch0_valid", 32'(bus.InstructionValid), 32'h1);
    fetch(BASE + 32'd4);
    chk("fetch1_instr", bus.Instruction, 32'h2009_0003);
    fetch(BASE + 32'd8);
    chk("fetch2_instr", bus.Instruction, 32'h0109_5020);
    chk("fetch2_fault", 32'(bus.Fault), 32'h0);
    fetch(BASE + 32'hC);
    chk("range_instr", bus.Instruction, 32'h0);
    chk("range_fault", 32'(bus.Fault), 32'h1);
    fetch(BASE + 32'd2);
    chk("align_fault", 32'(bus.Fault), 32'h1);
    fetch(32'h003F_FFFC);
    chk("below_fault", 32'(bus.Fault), 32'h1);
    bus.FetchEnable = 1'b0;
    cyc();
    chk("hold_valid", 32'(bus.InstructionValid), 32'h0);
    chk("hold_fault", 32'(bus.Fault), 32'h1);

    // Full-depth load without LoadLast; extra words are ignored.
    start_load();
    for (int i = 0; i < DEPTH; i++) load_word($urandom, 1'b0);
    chk("full_LoadCount", 32'(bus.LoadCount), DEPTH);
    chk("full_LoadDone", 32'(bus.LoadDone), 32'h1);
    for (int i = 0; i < 3; i++) begin
      bus.LoadData = $urandom;
      cyc();
      chk("full_LoadReady", 32'(bus.LoadReady), 32'h0);
      chk("full_count_hold", 32'(bus.LoadCount), DEPTH);
    end
    bus.LoadValid = 1'b0;
    fetch(BASE + 32'(4 * (DEPTH - 1)));
    chk("full_last_fault", 32'(bus.Fault), 32'h0);
    fetch(BASE + 32'(4 * DEPTH));
    chk("full_over_fault", 32'(bus.Fault), 32'h1);
    bus.FetchEnable = 1'b0;

    // Restart together with a valid word at LoadCount=5.
    start_load();
    for (int i = 0; i < 5; i++) load_word($urandom, 1'b0);
    chk("pre_restart_count", 32'(bus.LoadCount), 32'd5);
    bus.LoadStart = 1'b1;
    bus.LoadData  = 32'hDEAD_BEEF;
    #1;
    chk("restart_LoadReady", 32'(bus.LoadReady), 32'h0);
    cyc();
    bus.LoadStart = 1'b0;
    chk("restart_count", 32'(bus.LoadCount), 32'h0);
    cyc();
    load_word(32'h1111_1111, 1'b1);
    bus.LoadValid = 1'b0;
    bus.LoadLast  = 1'b0;
    chk("restart_done_count", 32'(bus.LoadCount), 32'd2);
    fetch(BASE);
    chk("restart_word0", bus.Instruction, 32'hDEAD_BEEF);
    fetch(BASE + 32'd4);
    chk("restart_word1", bus.Instruction, 32'h1111_1111);
    bus.FetchEnable = 1'b0;

    // Asynchronous reset in the middle of a load, then a fresh load.
    start_load();
    load_word(32'hAAAA_0001, 1'b0);
    load_word(32'hAAAA_0002, 1'b0);
    bus.LoadValid = 1'b0;
    #2 reset = 1'b0;
    #1;
    chk("midrst_LoadDone", 32'(bus.LoadDone), 32'h0);
    chk("midrst_LoadCount", 32'(bus.LoadCount), 32'h0);
    chk("midrst_LoadReady", 32'(bus.LoadReady), 32'h0);
    #2 reset = 1'b1;
    cyc();
    start_load();
    for (int i = 0; i < 4; i++) load_word(32'hC0DE_0000 + 32'(i), (i == 3) ? 1'b1 : 1'b0);
    bus.LoadValid = 1'b0;
    bus.LoadLast  = 1'b0;
    chk("fresh_LoadCount", 32'(bus.LoadCount), 32'd4);
    for (int i = 0; i < 4; i++) fetch(BASE + 32'(4 * i));
    chk("fresh_word3", bus.Instruction, 32'hC0DE_0003);
    bus.FetchEnable = 1'b0;

    // Random traffic checked against the model every cycle.
    for (int n = 0; n < 3000; n++) begin
      cyc();
      bus.LoadStart   = ($urandom_range(0, 40) == 0);
      bus.LoadValid   = $urandom_range(0, 1);
      bus.LoadLast    = ($urandom_range(0, 12) == 0);
      bus.LoadData    = $urandom;
      bus.FetchEnable = $urandom_range(0, 1);
      case ($urandom_range(0, 9))
        0:       bus.Address = $urandom;
        1:       bus.Address = BASE - 32'(4 * $urandom_range(1, 4));
        2:       bus.Address = BASE + 32'($urandom_range(0, 4 * DEPTH + 16));
        default: bus.Address = BASE + 32'(4 * $urandom_range(0, DEPTH + 1));
      endcase
      if ($urandom_range(0, 400) == 0) begin
        #2 reset = 1'b0;
        #3 reset = 1'b1;
      end
    end

    cyc();
    cmp_on = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/program_memory_loader.md
# program_memory_loader

Loadable, parametrised program memory for the MIPS fetch stage. Instructions are streamed in over a valid/ready boot-load port and then served on a registered fetch port. Each fetch has alignment and range checks. This block replaces the fixed, file-initialised ROM: the processor boots from whatever the loader delivers, with no dependence on a simulation-only init file.

## Interface
Parameters:
- MEMORY_DEPTH, 64, number of instruction words; need not be a power of two
- DATA_WIDTH, 32, instruction and address width
- BASE_ADDRESS, 32'h0040_0000, byte address of word 0 (MIPS text segment)

Ports:
- clk  in  1  single clock, all state on rising edge
- reset  in  1  asynchronous, active-low; clears all control state
- LoadStart  in  1  one-cycle pulse; (re)starts a load at word 0
- LoadData  in  DATA_WIDTH  instruction word being loaded
- LoadValid  in  1  LoadData valid
- LoadLast  in  1  qualifies LoadValid; marks the final word
- LoadReady  out  1  block accepts LoadData this cycle
- LoadDone  out  1  image loaded, fetch enabled
- LoadCount  out  $clog2(MEMORY_DEPTH+1)  words accepted in current/last load
- FetchEnable  in  1  request a fetch at Address
- Address  in  DATA_WIDTH  byte address (PC)
- Instruction  out  DATA_WIDTH  registered fetched word
- InstructionValid  out  1  Instruction updated by a successful or faulted fetch this cycle
- Fault  out  1  last fetch was misaligned or out of range

## Operation
- States: IDLE (reset state), LOADING, RUN.
- Any state with LoadStart=1 -> LOADING. LoadCount=0, LoadDone=0.
- Memory array is never reset. After reset, contents are unusable until a load completes.
- LOADING: LoadReady = ~LoadStart. On LoadValid & LoadReady:
  - write mem[LoadCount] = LoadData
  - LoadCount += 1
- LOADING -> RUN after accepting a word with LoadLast=1, or after accepting word MEMORY_DEPTH-1. LoadDone=1 on entering RUN.
- IDLE and RUN: LoadReady=0. LoadValid is ignored.
- RUN, FetchEnable=1: index = (Address - BASE_ADDRESS) >> 2. Fault if any of:
  - Address[1:0] != 0
  - Address < BASE_ADDRESS
  - index >= LoadCount
- On fault: Instruction = 32'h0000_0000 (NOP), Fault=1. Otherwise Instruction = mem[index], Fault=0.
- In both cases InstructionValid=1 for one cycle.
- FetchEnable outside RUN: no update; InstructionValid=0; Instruction and Fault hold.
- LoadStart during RUN: drops LoadDone immediately. Fetches stop being served from the next cycle.
- Reset values: state IDLE, LoadReady 0, LoadDone 0, LoadCount 0, Instruction 0, InstructionValid 0, Fault 0.

## Timing
- Fetch latency: 1 cycle. Address sampled at edge N; Instruction, InstructionValid and Fault valid after edge N.
- Back-to-back fetches sustain one per cycle.
- Load throughput: one word per cycle while LoadValid is held.
- LoadDone rises on the edge that accepts the last word.
- First fetch can be accepted the cycle after LoadDone is seen high.
- LoadStart together with LoadValid: restart wins and the word is not written. LoadReady is low that cycle, so the source holds its data.
- Reset asserted mid-load or mid-fetch: all outputs go to reset values immediately (asynchronous). A partially written image is abandoned.

## Structure
- Shared package contents:
  - state encoding (IDLE/LOADING/RUN)
  - NOP constant
  - default BASE_ADDRESS
  - ADDR_W = $clog2(MEMORY_DEPTH) helper
- Sub-module program_ram_dp: one synchronous write port and one synchronous read port, no reset. Infers block RAM.
- Top level contents: FSM, load counter, range/alignment check, and the output register for Fault/InstructionValid.
- The range check is pipelined alongside the RAM read so both align in the same cycle.

## Test plan
- Reset, then FetchEnable with Address=0x0040_0000 -> InstructionValid=0, Instruction=0, LoadDone=0.
- LoadStart, stream 0x2008_0005, 0x2009_0003, 0x0109_5020 with LoadLast on the third word -> LoadDone=1, LoadCount=3. Fetches at 0x0040_0000/04/08 return those words, one cycle later each.
- After the load above, fetch at 0x0040_000C (index 3 ≥ LoadCount) -> Instruction=0, Fault=1. Fetch at 0x0040_0002 -> Fault=1. Fetch at 0x003F_FFFC -> Fault=1.
- Load exactly MEMORY_DEPTH words without LoadLast -> RUN entered on the last word, LoadCount=MEMORY_DEPTH. Further LoadValid is ignored and LoadReady=0.
- LoadStart asserted together with LoadValid mid-load at LoadCount=5 -> LoadReady=0 that cycle, word not written, LoadCount=0 next cycle.
- Reset pulsed while LoadCount=2 -> LoadDone=0, LoadCount=0, state IDLE. A fresh load then succeeds.
